param_dcache: RTL and testbench

//  Parametrised write-back, write-allocate, N-way set-associative data cache between datapath and memory controller.

---
 rtl/param_dcache.sv | 269 ++++++++++++++++++++++++++
 tb/tb_param_dcache.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_dcache.sv
// Write-back, write-allocate, N-way set-associative data cache with true-LRU replacement.
// On halt it writes back every dirty frame, stores the hit count, then raises flushed.
module param_dcache #(
  parameter int          WAYS        = 2,
  parameter int          SETS        = 8,
  parameter int          BLK_WORDS   = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic [2:0]  dbg_state_o,
  output logic [31:0] dbg_miss_cnt_o
);
  localparam int OW     = $clog2(BLK_WORDS);
  localparam int IW     = $clog2(SETS);
  localparam int AW     = $clog2(WAYS);
  localparam int TW     = 30 - IW - OW;
  localparam int OWB    = (OW == 0) ? 1 : OW;
  localparam int AWB    = (AW == 0) ? 1 : AW;
  localparam int PW     = IW + AW;
  localparam int FRAMES = SETS * WAYS;

  typedef enum logic [2:0] {IDLE, WB, LOAD, FL_CHK, FL_WB, WR_CNT, FLUSHED} state_t;

  state_t         state_q, state_d;
  logic [OWB-1:0] ctr_q, ctr_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [AWB-1:0] vic_q, vic_d;
  logic [31:0]    hit_cnt_q, hit_cnt_d;
  logic [31:0]    miss_cnt_q, miss_cnt_d;

  logic           valid_q [WAYS][SETS];
  logic           dirty_q [WAYS][SETS];
  logic [TW-1:0]  tag_q   [WAYS][SETS];
  logic [AWB-1:0] age_q   [WAYS][SETS];
  logic [31:0]    data_q  [WAYS][SETS][BLK_WORDS];

  logic [29:0]     req_word;
  logic [OWB-1:0]  req_off;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [WAYS-1:0] way_hit;
  logic [AWB-1:0]  hit_way, vic_way;
  logic            vic_found;
  logic [AWB-1:0]  fl_way;
  logic [IW-1:0]   fl_set;
  logic            last_word, last_frame;
  logic            do_hit, do_inval, do_fill, do_fill_last, do_wb_clean, do_fl_clean;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^dmemaddr[1:0];
  assign req_word   = dmemaddr[31:2];
  assign req_off    = OWB'(req_word & 30'(BLK_WORDS - 1));
  assign req_idx    = IW'(req_word >> OW);
  assign req_tag    = TW'(req_word >> (OW + IW));
  assign fl_way     = AWB'(ptr_q >> IW);
  assign fl_set     = IW'(ptr_q);
  assign last_word  = (ctr_q == OWB'(BLK_WORDS - 1));
  assign last_frame = (ptr_q == PW'(FRAMES - 1));

  assign dbg_state_o    = state_q;
  assign dbg_miss_cnt_o = miss_cnt_q;

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IW-1:0] s,
                                          input logic [OWB-1:0] o);
    logic [29:0] w;
    w = (30'(t) << (IW + OW)) | (30'(s) << OW) | 30'(o);
    return {w, 2'b00};
  endfunction

  // Victim: lowest-index invalid way, otherwise the least recently used (age WAYS-1).
  always_comb begin
    way_hit   = '0;
    hit_way   = '0;
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
      if (way_hit[w]) hit_way = AWB'(w);
      if (!vic_found && !valid_q[w][req_idx]) begin
        vic_way   = AWB'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] == AWB'(WAYS - 1)) vic_way = AWB'(w);
      end
    end
  end

  // Memory handshake: dREN/dWEN is a held request (never both); a word moves on
  // every rising edge where the request is up and dwait is low.
  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    ptr_d        = ptr_q;
    vic_d        = vic_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    dhit         = 1'b0;
    dmemload     = '0;
    flushed      = 1'b0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    dstore       = '0;
    do_hit       = 1'b0;
    do_inval     = 1'b0;
    do_fill      = 1'b0;
    do_fill_last = 1'b0;
    do_wb_clean  = 1'b0;
    do_fl_clean  = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FL_CHK;
          ptr_d   = '0;
        end else if (dmemREN || dmemWEN) begin
          if (|way_hit) begin
            dhit      = 1'b1;
            do_hit    = 1'b1;
            hit_cnt_d = hit_cnt_q + 32'd1;
            if (dmemREN) dmemload = data_q[hit_way][req_idx][req_off];
          end else begin
            miss_cnt_d = miss_cnt_q + 32'd1;
            vic_d      = vic_way;
            ctr_d      = '0;
            if (valid_q[vic_way][req_idx] && dirty_q[vic_way][req_idx]) begin
              state_d = WB;
            end else begin
              state_d  = LOAD;
              do_inval = 1'b1;
            end
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[vic_q][req_idx], req_idx, ctr_q);
        dstore = data_q[vic_q][req_idx][ctr_q];
        if (!dwait) begin
          if (last_word) begin
            ctr_d       = '0;
            state_d     = LOAD;
            do_wb_clean = 1'b1;
            do_inval    = 1'b1;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end
      LOAD: begin
        dREN  = 1'b1;
        daddr = mk_addr(req_tag, req_idx, ctr_q);
        if (!dwait) begin
          do_fill = 1'b1;
          if (last_word) begin
            ctr_d        = '0;
            state_d      = IDLE;
            do_fill_last = 1'b1;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end
      FL_CHK: begin
        if (dirty_q[fl_way][fl_set]) begin
          state_d = FL_WB;
          ctr_d   = '0;
        end else if (last_frame) begin
          state_d = WR_CNT;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      FL_WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[fl_way][fl_set], fl_set, ctr_q);
        dstore = data_q[fl_way][fl_set][ctr_q];
        if (!dwait) begin
          if (last_word) begin
            ctr_d       = '0;
            do_fl_clean = 1'b1;
            if (last_frame) begin
              state_d = WR_CNT;
            end else begin
              ptr_d   = ptr_q + 1'b1;
              state_d = FL_CHK;
            end
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end
      WR_CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hit_cnt_q;
        if (!dwait) state_d = FLUSHED;
      end
      FLUSHED: flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      ptr_q      <= '0;
      vic_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          age_q[w][s]   <= AWB'(w);
        end
      end
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      ptr_q      <= ptr_d;
      vic_q      <= vic_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (do_hit) begin
        if (dmemWEN) dirty_q[hit_way][req_idx] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (AWB'(w) == hit_way) age_q[w][req_idx] <= '0;
          else if (age_q[w][req_idx] < age_q[hit_way][req_idx])
            age_q[w][req_idx] <= age_q[w][req_idx] + 1'b1;
        end
      end
      if (do_inval) valid_q[vic_d][req_idx] <= 1'b0;
      if (do_wb_clean) dirty_q[vic_q][req_idx] <= 1'b0;
      if (do_fill_last) begin
        valid_q[vic_q][req_idx] <= 1'b1;
        dirty_q[vic_q][req_idx] <= 1'b0;
        tag_q[vic_q][req_idx]   <= req_tag;
      end
      if (do_fl_clean) dirty_q[fl_way][fl_set] <= 1'b0;
    end
  end

  // Block storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (do_hit && dmemWEN) data_q[hit_way][req_idx][req_off] <= dmemstore;
    if (do_fill) data_q[vic_q][req_idx][ctr_q] <= dload;
  end

endmodule

// File: tb/tb_param_dcache.sv
// Bench for param_dcache: flat-memory + LRU-by-timestamp model, bus responder that checks
// every memory transfer against an expected queue, and directed scenarios.
module tb_param_dcache;
  localparam int          WAYS   = 2;
  localparam int          SETS   = 8;
  localparam int          BLK    = 2;
  localparam logic [31:0] HC_ADR = 32'h3100;
  localparam int          FRAMES = WAYS * SETS;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic [31:0] dload = '0;
  logic        dwait = 1'b0;
  logic [2:0]  dbg_state;
  logic [31:0] dbg_miss;

  param_dcache #(.WAYS(WAYS), .SETS(SETS), .BLK_WORDS(BLK), .HITCNT_ADDR(HC_ADR)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .dbg_state_o(dbg_state), .dbg_miss_cnt_o(dbg_miss)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // environment memory (what the bus holds) and golden flat memory (what the datapath sees)
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] golden  [logic [31:0]];

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : (a ^ 32'hC0DE0000);
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : (a ^ 32'hC0DE0000);
  endfunction

  // model: per frame valid/tag/dirty plus last-use timestamp
  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  int          m_tag   [WAYS][SETS];
  longint      m_ts    [WAYS][SETS];
  longint      m_now;
  int          m_miss, m_hits;
  int          stall_n, wait_cnt;
  logic [64:0] exp_q[$];   // {is_write, addr, data}

  function automatic logic [31:0] blk_addr(input int tag, input int set, input int k);
    return 32'(((tag * SETS + set) * BLK + k) * 4);
  endfunction

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 0; m_dirty[w][s] = 0; m_tag[w][s] = 0; m_ts[w][s] = 0;
      end
    m_now = 0; m_miss = 0; m_hits = 0; stall_n = 0; wait_cnt = 0;
    exp_q.delete(); bus_mem.delete(); golden.delete();
  endtask

  task automatic predict(input bit wr, input logic [31:0] addr, output int lat);
    int word, set, tag, hw, v;
    bit wb;
    word = int'(addr >> 2);
    set  = (word / BLK) % SETS;
    tag  = word / (BLK * SETS);
    hw   = -1;
    lat  = 0;
    for (int w = 0; w < WAYS; w++) if (m_valid[w][set] && m_tag[w][set] == tag) hw = w;
    if (hw < 0) begin
      m_miss++;
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[w][set]) v = w;
      if (v < 0) begin
        v = 0;
        for (int w = 1; w < WAYS; w++) if (m_ts[w][set] < m_ts[v][set]) v = w;
      end
      wb = m_valid[v][set] && m_dirty[v][set];
      if (wb)
        for (int k = 0; k < BLK; k++)
          exp_q.push_back({1'b1, blk_addr(m_tag[v][set], set, k),
                           gold_rd(blk_addr(m_tag[v][set], set, k))});
      for (int k = 0; k < BLK; k++) exp_q.push_back({1'b0, blk_addr(tag, set, k), 32'h0});
      m_valid[v][set] = 1; m_dirty[v][set] = 0; m_tag[v][set] = tag;
      hw  = v;
      lat = 1 + (wb ? 2 : 1) * BLK * (1 + stall_n);
    end
    m_now++;
    m_ts[hw][set] = m_now;
    if (wr) m_dirty[hw][set] = 1;
    m_hits++;
  endtask

  task automatic flush_predict();
    for (int p = 0; p < FRAMES; p++) begin
      int w, s;
      w = p / SETS;
      s = p % SETS;
      if (m_valid[w][s] && m_dirty[w][s])
        for (int k = 0; k < BLK; k++)
          exp_q.push_back({1'b1, blk_addr(m_tag[w][s], s, k), gold_rd(blk_addr(m_tag[w][s], s, k))});
    end
    exp_q.push_back({1'b1, HC_ADR, 32'(m_hits)});
  endtask

  // compare process: bus transfers against the expected queue, plus idle sanity
  always @(negedge CLK) begin
    if (nRST) begin
      chk("rw_excl", {31'b0, dREN & dWEN}, 32'd0);
      if (!dmemREN && !dmemWEN) chk("idle_no_dhit", {31'b0, dhit}, 32'd0);
      if (dREN || dWEN) begin
        chk("xfer_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          chk("xfer_kind", {31'b0, dWEN}, {31'b0, exp_q[0][64]});
          chk("xfer_addr", daddr, exp_q[0][63:32]);
          if (dWEN) chk("xfer_data", dstore, exp_q[0][31:0]);
        end
        if (wait_cnt < stall_n) begin
          dwait = 1'b1;
          wait_cnt++;
        end else begin
          dwait    = 1'b0;
          wait_cnt = 0;
          if (dWEN) bus_mem[daddr] = dstore;
          else dload = bus_rd(daddr);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else begin
        dwait = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    nRST = 1'b0;
    halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0; dwait = 1'b0;
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_ctrl", {28'b0, dhit, dREN, dWEN, flushed}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);
    chk("rst_miss", dbg_miss, 32'd0);
    #2 nRST = 1'b1;
  endtask

  task automatic access(input bit ren, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat_seen,
                        output logic [31:0] rd_seen);
    int  lat;
    bit  done;
    predict(wen, addr, lat);
    @(posedge CLK); #1;
    dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = wdata;
    done = 0; lat_seen = -1; rd_seen = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge CLK);
      if (dhit) begin
        done     = 1;
        lat_seen = c;
        rd_seen  = dmemload;
      end
    end
    if (!done) begin
      chk("dhit_timeout", {31'b0, dhit}, 32'd1);
    end else begin
      chk("latency", 32'(lat_seen), 32'(lat));
      chk("xfers_done", 32'(exp_q.size()), 32'd0);
      if (ren && !wen) chk("rdata", rd_seen, gold_rd(addr));
    end
    if (wen) golden[addr] = wdata;
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
    chk("miss_cnt", dbg_miss, 32'(m_miss));
  endtask

  task automatic do_flush();
    bit done;
    flush_predict();
    @(posedge CLK); #1;
    halt = 1'b1;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge CLK);
      if (flushed) done = 1;
    end
    if (!done) chk("flush_timeout", {31'b0, flushed}, 32'd1);
    chk("flush_xfers", 32'(exp_q.size()), 32'd0);
    repeat (6) begin
      @(negedge CLK);
      chk("flushed_held", {31'b0, flushed}, 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          lat_seen;
  logic [31:0] rd_seen;
  int          lat_d;

  initial begin
    // 1: cold read miss, two-word load, then hit
    do_reset();
    access(1, 0, 32'h0000, 32'h0, lat_seen, rd_seen);
    chk("t1_rdata_lit", rd_seen, 32'hC0DE0000);
    chk("t1_lat_lit", 32'(lat_seen), 32'd3);
    chk("t1_miss_lit", dbg_miss, 32'd1);

    // 2: dirty victim written back before the new block loads
    access(0, 1, 32'h0000, 32'h0000AAAA, lat_seen, rd_seen);
    chk("t2_whit_lat_lit", 32'(lat_seen), 32'd0);
    access(1, 0, 32'h0040, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0080, 32'h0, lat_seen, rd_seen);
    chk("t2_wb_lat_lit", 32'(lat_seen), 32'd5);
    chk("t2_wb_mem_lit", bus_rd(32'h0000), 32'h0000AAAA);
    access(1, 0, 32'h0000, 32'h0, lat_seen, rd_seen);
    chk("t2_reload_lit", rd_seen, 32'h0000AAAA);

    // 3: LRU ordering
    do_reset();
    access(1, 0, 32'h0000, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0040, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0000, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0040, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0000, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0080, 32'h0, lat_seen, rd_seen);
    access(1, 0, 32'h0004, 32'h0, lat_seen, rd_seen);
    chk("t3_keep_0000_lit", 32'(lat_seen), 32'd0);
    chk("t3_word1_lit", rd_seen, 32'hC0DE0004);
    access(1, 0, 32'h0040, 32'h0, lat_seen, rd_seen);
    chk("t3_evicted_0040_lit", 32'(lat_seen), 32'd3);

    // 4: memory stalls, then REN+WEN together acts as a write
    stall_n = 5;
    access(1, 0, 32'h0010, 32'h0, lat_seen, rd_seen);
    chk("t4_stall_lat_lit", 32'(lat_seen), 32'd13);
    stall_n = 0;
    access(1, 1, 32'h0014, 32'h00001234, lat_seen, rd_seen);
    access(1, 0, 32'h0014, 32'h0, lat_seen, rd_seen);
    chk("t4_rw_prio_lit", rd_seen, 32'h00001234);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(($urandom_range(0, 3) << 6) | (i << 3) | ($urandom_range(0, 1) << 2));
      access(1, 0, a, 32'h0, lat_seen, rd_seen);
      access(0, 1, a, 32'hBEEF0000 | a, lat_seen, rd_seen);
    end

    // 5: halt flushes set0/way0 and set7/way1, then writes the hit count
    do_reset();
    access(0, 1, 32'h0000, 32'h11110000, lat_seen, rd_seen);
    access(1, 0, 32'h0038, 32'h0, lat_seen, rd_seen);
    access(0, 1, 32'h0078, 32'h77770078, lat_seen, rd_seen);
    chk("t5_queue_lit", 32'(exp_q.size()), 32'd0);
    do_flush();
    chk("t5_hitcnt_lit", bus_rd(HC_ADR), 32'd3);
    chk("t5_set0_lit", bus_rd(32'h0000), 32'h11110000);
    chk("t5_set7_lit", bus_rd(32'h0078), 32'h77770078);
    chk("t5_set7_w1_lit", bus_rd(32'h007C), 32'hC0DE007C);

    // 6: asynchronous reset in the middle of a load
    do_reset();
    predict(0, 32'h0200, lat_d);
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h0200;
    repeat (3) @(negedge CLK);
    chk("t6_in_load", {31'b0, dREN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_async_state", {29'b0, dbg_state}, 32'd0);
    chk("t6_async_dren", {31'b0, dREN}, 32'd0);
    chk("t6_async_dhit", {31'b0, dhit}, 32'd0);
    do_reset();
    access(1, 0, 32'h0200, 32'h0, lat_seen, rd_seen);
    chk("t6_miss_again_lit", dbg_miss, 32'd1);
    chk("t6_lat_lit", 32'(lat_seen), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
